// File: rtl/galaxian_pkg.sv
// Shared Galaxian definitions: formation size, pixel coordinate type and
// the hit-detector scan states.
package galaxian_pkg;

    localparam int unsigned NUM_ALIENS     = 12;
    localparam int unsigned ALIENS_PER_ROW = 6;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } hit_state_t;

endpackage

// File: rtl/alien_box_cmp.sv
// Combinational inclusive-bounds test of a point against one alien hit box
// whose top-left corner is (xl, yt).
module alien_box_cmp
    import galaxian_pkg::*;
#(
    parameter int unsigned ALIEN_W = 24,
    parameter int unsigned ALIEN_H = 16
) (
    input  logic [10:0] xl,
    input  logic [10:0] yt,
    input  coord_t      px,
    input  coord_t      py,
    output logic        hit
);

    logic [11:0] xl_w, yt_w, xr_w, yb_w, px_w, py_w;

    // One extra bit of headroom so the right/bottom edges never wrap.
    always_comb begin
        xl_w = {1'b0, xl};
        yt_w = {1'b0, yt};
        px_w = {2'b00, px};
        py_w = {2'b00, py};
        xr_w = xl_w + 12'(ALIEN_W) - 12'd1;
        yb_w = yt_w + 12'(ALIEN_H) - 12'd1;
        hit  = (px_w >= xl_w) && (px_w <= xr_w) &&
               (py_w >= yt_w) && (py_w <= yb_w);
    end

endmodule

// File: rtl/alien_hit_detector.sv
// Per-frame serial scan of the 12-alien formation against the player missile;
// produces sticky hit flags, a missile-retire pulse and an explosion timer.
module alien_hit_detector
    import galaxian_pkg::*;
#(
    parameter int unsigned COL_PITCH      = 32,
    parameter int unsigned ROW_PITCH      = 32,
    parameter int unsigned ALIEN_W        = 24,
    parameter int unsigned ALIEN_H        = 16,
    parameter int unsigned EXPLODE_FRAMES = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        wave_clear,
    input  logic        missile_active,
    input  coord_t      missile_x,
    input  coord_t      missile_y,
    input  coord_t      form_x,
    input  coord_t      form_y,
    output logic [11:0] alien_hit,
    output logic        all_hit,
    output logic        missile_hit,
    output logic        explode_active,
    output logic [3:0]  explode_idx,
    output logic        busy
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ALIENS - 1);
    localparam logic [3:0] ROW_LEN  = 4'(ALIENS_PER_ROW);

    hit_state_t  state_q;
    logic [3:0]  idx_q;
    coord_t      mx_q, my_q, fx_q, fy_q;
    logic [11:0] hit_q;
    logic        mhit_q;
    logic [3:0]  ecnt_q;
    logic [3:0]  eidx_q;

    logic        row;
    logic [2:0]  col;
    logic [10:0] xl, yt;
    logic        box_hit;
    logic        match;

    always_comb begin
        row = (idx_q >= ROW_LEN);
        col = row ? 3'(idx_q - ROW_LEN) : idx_q[2:0];
        xl  = {1'b0, fx_q} + 11'(32'(col) * COL_PITCH);
        yt  = {1'b0, fy_q} + (row ? 11'(ROW_PITCH) : 11'd0);
    end

    alien_box_cmp #(
        .ALIEN_W (ALIEN_W),
        .ALIEN_H (ALIEN_H)
    ) u_cmp (
        .xl  (xl),
        .yt  (yt),
        .px  (mx_q),
        .py  (my_q),
        .hit (box_hit)
    );

    assign match = box_hit && !hit_q[idx_q];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            hit_q   <= '0;
            mhit_q  <= 1'b0;
            ecnt_q  <= '0;
            eidx_q  <= '0;
        end else if (wave_clear) begin
            state_q <= IDLE;
            hit_q   <= '0;
            mhit_q  <= 1'b0;
            ecnt_q  <= '0;
            eidx_q  <= '0;
        end else begin
            mhit_q <= 1'b0;
            // A hit below reloads the counter, overriding this decrement.
            if (frame_tick && (ecnt_q != '0))
                ecnt_q <= ecnt_q - 4'd1;
            unique case (state_q)
                IDLE: begin
                    if (frame_tick && missile_active) begin
                        mx_q    <= missile_x;
                        my_q    <= missile_y;
                        fx_q    <= form_x;
                        fy_q    <= form_y;
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        hit_q[idx_q] <= 1'b1;
                        mhit_q       <= 1'b1;
                        eidx_q       <= idx_q;
                        ecnt_q       <= 4'(EXPLODE_FRAMES);
                        state_q      <= DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alien_hit      = hit_q;
    assign all_hit        = &hit_q;
    assign missile_hit    = mhit_q;
    assign explode_active = (ecnt_q != '0);
    assign explode_idx    = eidx_q;
    assign busy           = (state_q != IDLE);

endmodule
